// File: rtl/frame_sched_pkg.sv
// Shared constants for the frame scheduler: state encoding, frame length helper, framing word.
package frame_sched_pkg;

    localparam int DEF_PRBS_LENGTH = 8;

    function automatic int frame_len(input int prbs_length);
        return prbs_length + 2;
    endfunction

    localparam int FRAME_LEN = frame_len(DEF_PRBS_LENGTH);

    localparam logic [9:0] HEAD_TAIL_WORD = 10'b1100110011;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_FRAME = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        ISSUE = S_ISSUE,
        FRAME = S_FRAME,
        GAP   = S_GAP,
        DONE  = S_DONE
    } state_e;

endpackage

// File: rtl/frame_sched_if.sv
// Control/status bundle between a burst controller (master) and frame_sched (slave).
interface frame_sched_if #(
    parameter int GAP_W = 16,
    parameter int CNT_W = 32
);
    logic             start;
    logic             stop;
    logic [15:0]      cfg_frames;
    logic [GAP_W-1:0] cfg_gap;
    logic             send_enable;
    logic             frame_start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_sent;

    modport master (
        output start, stop, cfg_frames, cfg_gap,
        input  send_enable, frame_start, busy, done, frames_sent
    );

    modport slave (
        input  start, stop, cfg_frames, cfg_gap,
        output send_enable, frame_start, busy, done, frames_sent
    );
endinterface

// File: rtl/frame_sched.sv
// Burst scheduler pacing a frame generator: send_enable one cycle before each head, period FRAME_LEN+gap.
// No backpressure: start/stop are single-cycle pulses; outputs decoded from state and counters only.
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int PRBS_LENGTH = DEF_PRBS_LENGTH,
    parameter int GAP_W       = 16,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    frame_sched_if.slave bus
);
    localparam int FLEN  = frame_len(PRBS_LENGTH);
    localparam int CYC_W = (FLEN > 1) ? $clog2(FLEN) : 1;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(FLEN - 1);

    state_e           state;
    logic [CYC_W-1:0] cyc_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_q;
    logic [15:0]      frames_q;
    logic [15:0]      left_cnt;
    logic [CNT_W-1:0] sent_cnt;
    logic             stop_pending;

    logic tail;
    logic last_frame;
    logic end_burst;

    assign tail       = (state == FRAME) && (cyc_cnt == LAST_CYC);
    // frames_q == 0 means continuous: left_cnt never reaches the last-frame value
    assign last_frame = (frames_q != 16'd0) && (left_cnt == 16'd1);
    assign end_burst  = last_frame || stop_pending;

    assign bus.send_enable = (state == ISSUE) || (tail && !end_burst && (gap_q == '0));
    assign bus.frame_start = (state == FRAME) && (cyc_cnt == '0);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.frames_sent = sent_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            gap_cnt      <= '0;
            gap_q        <= '0;
            frames_q     <= '0;
            left_cnt     <= '0;
            sent_cnt     <= '0;
            stop_pending <= 1'b0;
        end else begin
            // A stop seen in the tail cycle only takes effect after any frame issued there completes
            if (bus.stop && (state != IDLE)) begin
                stop_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        frames_q     <= bus.cfg_frames;
                        left_cnt     <= bus.cfg_frames;
                        gap_q        <= bus.cfg_gap;
                        sent_cnt     <= '0;
                        stop_pending <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    cyc_cnt <= '0;
                    state   <= FRAME;
                end
                FRAME: begin
                    if (tail) begin
                        sent_cnt <= sent_cnt + CNT_W'(1);
                        if (frames_q != 16'd0) begin
                            left_cnt <= left_cnt - 16'd1;
                        end
                        if (end_burst) begin
                            state <= DONE;
                        end else if (gap_q == '0) begin
                            cyc_cnt <= '0;
                        end else if (gap_q == GAP_W'(1)) begin
                            state <= ISSUE;
                        end else begin
                            gap_cnt <= gap_q - GAP_W'(2);
                            state   <= GAP;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                GAP: begin
                    if (bus.stop || stop_pending) begin
                        state <= DONE;
                    end else if (gap_cnt == '0) begin
                        state <= ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    stop_pending <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched with PRBS_LENGTH=8: per-cycle output maps against hand-derived schedules.
module tb_frame_sched;
    logic clk;
    logic rst_n;

    frame_sched_if #(.GAP_W(16), .CNT_W(32)) bus ();

    frame_sched #(.PRBS_LENGTH(8), .GAP_W(16), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] se_map;
    logic [63:0] fs_map;
    logic [63:0] done_map;
    logic [63:0] busy_map;
    logic [31:0] sent_at [0:63];

    // Cycle 0 is the cycle in which start is presented; map bit k reflects outputs during cycle k.
    task automatic run(input int frames, input int gap, input int stop_at,
                       input int extra_start_at, input int ncyc);
        se_map = '0; fs_map = '0; done_map = '0; busy_map = '0;
        @(negedge clk);
        se_map[0] = bus.send_enable; fs_map[0] = bus.frame_start;
        done_map[0] = bus.done; busy_map[0] = bus.busy; sent_at[0] = bus.frames_sent;
        bus.cfg_frames = 16'(frames);
        bus.cfg_gap    = 16'(gap);
        bus.start      = 1'b1;
        bus.stop       = 1'b0;
        for (int k = 1; k < ncyc; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            se_map[k]   = bus.send_enable;
            fs_map[k]   = bus.frame_start;
            done_map[k] = bus.done;
            busy_map[k] = bus.busy;
            sent_at[k]  = bus.frames_sent;
            if (k == stop_at) bus.stop = 1'b1;
            if (k == extra_start_at) begin
                bus.start      = 1'b1;
                bus.cfg_frames = 16'd4;
                bus.cfg_gap    = 16'd0;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    function automatic logic [63:0] range_mask(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic test_reset;
        logic [35:0] outs;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_frames = '0; bus.cfg_gap = '0;
        repeat (3) @(negedge clk);
        outs = {bus.send_enable, bus.frame_start, bus.busy, bus.done, bus.frames_sent};
        checks++;
        if (outs !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy got=%b want=0", bus.busy);
        end
    endtask

    task automatic test_basic;
        logic [63:0] e;
        run(3, 2, -1, -1, 45);
        e = (64'd1 << 1) | (64'd1 << 13) | (64'd1 << 25);
        checks++;
        if (se_map !== e) begin errors++; $display("FAIL basic_send_enable got=%h want=%h", se_map, e); end
        e = (64'd1 << 2) | (64'd1 << 14) | (64'd1 << 26);
        checks++;
        if (fs_map !== e) begin errors++; $display("FAIL basic_frame_start got=%h want=%h", fs_map, e); end
        e = 64'd1 << 36;
        checks++;
        if (done_map !== e) begin errors++; $display("FAIL basic_done got=%h want=%h", done_map, e); end
        e = range_mask(1, 36);
        checks++;
        if (busy_map !== e) begin errors++; $display("FAIL basic_busy got=%h want=%h", busy_map, e); end
        checks++;
        if (sent_at[11] !== 32'd0 || sent_at[12] !== 32'd1) begin
            errors++;
            $display("FAIL basic_tail_increment got=%0d,%0d want=0,1", sent_at[11], sent_at[12]);
        end
        checks++;
        if (bus.frames_sent !== 32'd3) begin errors++; $display("FAIL basic_frames_sent got=%0d want=3", bus.frames_sent); end
    endtask

    task automatic test_start_stop_idle;
        bus.cfg_frames = 16'd1; bus.cfg_gap = 16'd0;
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        se_map = '0; busy_map = '0;
        for (int k = 0; k < 15; k++) begin
            se_map[k]   = bus.send_enable;
            busy_map[k] = bus.busy;
            @(negedge clk);
        end
        checks++;
        if ((se_map | busy_map) !== 64'd0) begin
            errors++;
            $display("FAIL start_stop_idle got se=%h busy=%h want=0", se_map, busy_map);
        end
        checks++;
        if (bus.frames_sent !== 32'd3) begin errors++; $display("FAIL start_stop_idle_count got=%0d want=3", bus.frames_sent); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] e;
        run(2, 0, -1, -1, 30);
        e = (64'd1 << 1) | (64'd1 << 11);
        checks++;
        if (se_map !== e) begin errors++; $display("FAIL b2b_send_enable got=%h want=%h", se_map, e); end
        e = (64'd1 << 2) | (64'd1 << 12);
        checks++;
        if (fs_map !== e) begin errors++; $display("FAIL b2b_frame_start got=%h want=%h", fs_map, e); end
        e = 64'd1 << 22;
        checks++;
        if (done_map !== e) begin errors++; $display("FAIL b2b_done got=%h want=%h", done_map, e); end
        checks++;
        if (bus.frames_sent !== 32'd2) begin errors++; $display("FAIL b2b_frames_sent got=%0d want=2", bus.frames_sent); end
    endtask

    task automatic test_continuous_stop;
        logic [63:0] e;
        run(0, 1, 30, -1, 45);
        e = (64'd1 << 1) | (64'd1 << 12) | (64'd1 << 23);
        checks++;
        if (se_map !== e) begin errors++; $display("FAIL cont_send_enable got=%h want=%h", se_map, e); end
        e = (64'd1 << 2) | (64'd1 << 13) | (64'd1 << 24);
        checks++;
        if (fs_map !== e) begin errors++; $display("FAIL cont_frame_start got=%h want=%h", fs_map, e); end
        e = 64'd1 << 34;
        checks++;
        if (done_map !== e) begin errors++; $display("FAIL cont_done got=%h want=%h", done_map, e); end
        checks++;
        if (sent_at[33] !== 32'd2 || sent_at[34] !== 32'd3) begin
            errors++;
            $display("FAIL cont_tail_at_33 got=%0d,%0d want=2,3", sent_at[33], sent_at[34]);
        end
    endtask

    task automatic test_stop_in_gap;
        logic [63:0] e;
        run(5, 8, 14, -1, 30);
        e = 64'd1 << 1;
        checks++;
        if (se_map !== e) begin errors++; $display("FAIL gapstop_send_enable got=%h want=%h", se_map, e); end
        e = 64'd1 << 15;
        checks++;
        if (done_map !== e) begin errors++; $display("FAIL gapstop_done got=%h want=%h", done_map, e); end
        e = range_mask(1, 15);
        checks++;
        if (busy_map !== e) begin errors++; $display("FAIL gapstop_busy got=%h want=%h", busy_map, e); end
        checks++;
        if (bus.frames_sent !== 32'd1) begin errors++; $display("FAIL gapstop_frames_sent got=%0d want=1", bus.frames_sent); end
    endtask

    task automatic test_start_while_busy;
        logic [63:0] e;
        run(2, 2, -1, 5, 35);
        e = (64'd1 << 1) | (64'd1 << 13);
        checks++;
        if (se_map !== e) begin errors++; $display("FAIL busystart_send_enable got=%h want=%h", se_map, e); end
        e = 64'd1 << 24;
        checks++;
        if (done_map !== e) begin errors++; $display("FAIL busystart_done got=%h want=%h", done_map, e); end
        checks++;
        if (bus.frames_sent !== 32'd2) begin errors++; $display("FAIL busystart_frames_sent got=%0d want=2", bus.frames_sent); end
    endtask

    task automatic test_reset_mid_frame;
        logic [35:0] outs;
        logic        saw_activity;
        @(negedge clk);
        bus.cfg_frames = 16'd3; bus.cfg_gap = 16'd2; bus.start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL midreset_running got=%b want=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        outs = {bus.send_enable, bus.frame_start, bus.busy, bus.done, bus.frames_sent};
        checks++;
        if (outs !== 36'd0) begin errors++; $display("FAIL midreset_outputs got=%h want=0", outs); end
        saw_activity = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            saw_activity = saw_activity | bus.done | bus.busy | bus.send_enable;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            saw_activity = saw_activity | bus.done | bus.busy | bus.send_enable;
        end
        checks++;
        if (saw_activity !== 1'b0) begin errors++; $display("FAIL midreset_no_done got=%b want=0", saw_activity); end
        bus.cfg_frames = 16'd1; bus.cfg_gap = 16'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.send_enable !== 1'b1) begin errors++; $display("FAIL midreset_restart_se got=%b want=1", bus.send_enable); end
        @(negedge clk);
        checks++;
        if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL midreset_restart_head got=%b want=1", bus.frame_start); end
        repeat (12) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.frames_sent !== 32'd1) begin
            errors++;
            $display("FAIL midreset_restart_end got busy=%b sent=%0d want busy=0 sent=1", bus.busy, bus.frames_sent);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_stop_idle();
        test_back_to_back();
        test_continuous_stop();
        test_stop_in_gap();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 Parameter PRBS_LENGTH, default 8: PRBS words per frame; FRAME_LEN = PRBS_LENGTH+2 (head + PRBS + tail).
REQ-002 Parameter GAP_W, default 16: width of gap configuration.
REQ-003 Parameter CNT_W, default 32: width of frames_sent.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse: latch config, begin burst.
REQ-007 stop  in  1  one-cycle pulse: end burst after the current frame.
REQ-008 cfg_frames  in  16  frames per burst; 0 = continuous until stop.
REQ-009 cfg_gap  in  GAP_W  idle cycles between a tail word and the next head word.
REQ-010 send_enable  out  1  drives the frame generator's send_enable.
REQ-011 frame_start  out  1  pulse in each head-word cycle.
REQ-012 busy  out  1  high whenever state != IDLE.
REQ-013 done  out  1  one-cycle pulse at burst end.
REQ-014 frames_sent  out  CNT_W  frames completed since the last accepted start.

Function
REQ-015 The block SHALL use states IDLE, ISSUE, FRAME, GAP and DONE.
REQ-016 IDLE: a start without stop SHALL latch cfg_frames/cfg_gap, clear frames_sent and go to ISSUE; start with stop in the same cycle SHALL be ignored.
REQ-017 ISSUE: send_enable=1 for exactly one cycle, then FRAME with the cycle counter at 0.
REQ-018 FRAME SHALL last FRAME_LEN cycles (head..tail); frame_start=1 when the counter is 0.
REQ-019 In the tail cycle frames_sent SHALL increment, wrapping at 2^CNT_W.
REQ-020 Tail cycle, last frame or stop pending: next state DONE.
REQ-021 Tail cycle, more frames, gap=0: send_enable=1 in that tail cycle; stay in FRAME with the counter at 0 (back-to-back).
REQ-022 Tail cycle, more frames, gap=1: next state ISSUE; gap>=2: GAP for gap-1 cycles, then ISSUE.
REQ-023 Frame period SHALL equal FRAME_LEN + gap cycles.
REQ-024 stop while busy SHALL set stop_pending; a frame in progress, including one issued in the same cycle, SHALL complete its tail.
REQ-025 stop during GAP SHALL go to DONE next cycle with no further send_enable.
REQ-026 DONE SHALL set done=1 for one cycle, clear stop_pending and return to IDLE.
REQ-027 start while busy SHALL be ignored, and config changes while busy SHALL have no effect.
REQ-028 send_enable, frame_start and done SHALL be decoded combinationally from the state and counters, never from start or stop directly.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, clear all counters and stop_pending, and drive send_enable, frame_start, busy and done to 0.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse; the system resets the generator concurrently.
REQ-031 After rst_n deasserts, the first start SHALL behave as in REQ-016.

Structure
REQ-032 A shared package SHALL hold the state encoding localparams and FRAME_LEN.
REQ-033 Shared constants SHALL include the head/tail word 10'b1100110011 for bench checking.
REQ-034 No sub-module: FSM, cycle counter, gap counter and frame counter SHALL be inline; the frame generator is instantiated beside it at the parent level.

Verification (PRBS_LENGTH=8, FRAME_LEN=10, start sampled at cycle 0)
REQ-035 frames=3, gap=2 -> send_enable at cycles 1, 13, 25; frame_start at 2, 14, 26; done at 36; frames_sent=3; busy 1..36.
REQ-036 frames=2, gap=0 -> send_enable at 1 and 11 (tail cycle); heads at 2 and 12; done at 22; generator output has no idle word between the frames.
REQ-037 frames=0, gap=1, stop at cycle 30 -> ISSUE at 1, 12, 23; the third frame completes its tail at 33; done at 34; frames_sent=3.
REQ-038 frames=5, gap=8, stop at cycle 14 (in GAP) -> done at 15; no send_enable after cycle 1; frames_sent=1.
REQ-039 rst_n low at cycle 6 mid-frame -> all outputs 0 in the same cycle; no done; a start after release gives send_enable one cycle later.
REQ-040 start pulsed at cycle 5 while busy, and start+stop together in IDLE -> both ignored: no extra send_enable, frames_sent unchanged.
